// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// Optional statistics counters are enabled by defining ROM_ARB_STATS_EN.
module rom_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int BE_W       = 4,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_debugaccess,
    output logic              ram_clken,
    output logic              ram_reset_req,
    input  logic [DATA_W-1:0] ram_readdata
`ifdef ROM_ARB_STATS_EN
    ,
    input  logic              stat_clear,
    output logic [15:0]       stat_conflicts,
    output logic [15:0]       stat_m1_stalls
`endif
);

    localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic              w_req0;
    logic              w_req1;
    logic              w_gnt_vld;
    logic              w_gnt_sel;
    logic              w_sel_wr;
    logic              w_sel_rd;
    logic              w_gnt_rd;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [BE_W-1:0]   w_sel_be;
    logic [DATA_W-1:0] w_sel_wd;

    logic              r_last_grant;
    logic [3:0]        r_run_cnt;
    logic              r_vld_p1;
    logic              r_owner_p1;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Stage p0: arbitration. A run count of 0 means no run in progress, so a
    // tie then goes to the master that was not granted last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_sel = 1'b0;
        if (!reset) begin
            if (w_req0 && w_req1) begin
                w_gnt_vld = 1'b1;
                if ((r_run_cnt != 4'd0) && (r_run_cnt < MAX_C))
                    w_gnt_sel = r_last_grant;
                else
                    w_gnt_sel = ~r_last_grant;
            end else if (w_req0) begin
                w_gnt_vld = 1'b1;
                w_gnt_sel = 1'b0;
            end else if (w_req1) begin
                w_gnt_vld = 1'b1;
                w_gnt_sel = 1'b1;
            end
        end
    end

    assign w_sel_wr   = w_gnt_sel ? m1_write      : m0_write;
    assign w_sel_rd   = w_gnt_sel ? m1_read       : m0_read;
    assign w_sel_addr = w_gnt_sel ? m1_address    : m0_address;
    assign w_sel_be   = w_gnt_sel ? m1_byteenable : m0_byteenable;
    assign w_sel_wd   = w_gnt_sel ? m1_writedata  : m0_writedata;
    assign w_gnt_rd   = w_gnt_vld & ~w_sel_wr & w_sel_rd;

    assign m0_waitrequest = ~(w_gnt_vld & ~w_gnt_sel);
    assign m1_waitrequest = ~(w_gnt_vld &  w_gnt_sel);

    assign ram_chipselect  = w_gnt_vld;
    assign ram_write       = w_gnt_vld & w_sel_wr;
    assign ram_debugaccess = w_gnt_vld & w_sel_wr;
    assign ram_address     = w_gnt_vld ? w_sel_addr : '0;
    assign ram_byteenable  = w_gnt_vld ? w_sel_be   : '0;
    assign ram_writedata   = w_gnt_vld ? w_sel_wd   : '0;
    assign ram_clken       = 1'b1;
    assign ram_reset_req   = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_run_cnt    <= 4'd0;
            r_vld_p1     <= 1'b0;
        end else begin
            r_vld_p1 <= w_gnt_rd;
            if (w_gnt_vld) begin
                r_last_grant <= w_gnt_sel;
                if ((w_gnt_sel == r_last_grant) && (r_run_cnt != 4'd0))
                    r_run_cnt <= sat_inc4(r_run_cnt);
                else
                    r_run_cnt <= 4'd1;
            end else begin
                r_run_cnt <= 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt_rd)
            r_owner_p1 <= w_gnt_sel;
    end

    // Stage p1: RAM q is steered to the owner of the read issued last cycle.
    assign m0_readdatavalid = r_vld_p1 & ~r_owner_p1;
    assign m1_readdatavalid = r_vld_p1 &  r_owner_p1;
    assign m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? ram_readdata : '0;

`ifdef ROM_ARB_STATS_EN
    logic [15:0] r_stat_conflicts;
    logic [15:0] r_stat_m1_stalls;

    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            r_stat_conflicts <= 16'd0;
            r_stat_m1_stalls <= 16'd0;
        end else begin
            if (w_req0 && w_req1)
                r_stat_conflicts <= sat_inc16(r_stat_conflicts);
            if (w_req1 && !(w_gnt_vld && w_gnt_sel))
                r_stat_m1_stalls <= sat_inc16(r_stat_m1_stalls);
        end
    end

    assign stat_conflicts = r_stat_conflicts;
    assign stat_m1_stalls = r_stat_m1_stalls;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: two instances (MAX_CONSEC=4 and =1) on shared stimulus.
module tb_rom_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;

    logic [DW-1:0] a_m0_readdata, a_m1_readdata, b_m0_readdata, b_m1_readdata;
    logic          a_m0_waitrequest, a_m1_waitrequest, b_m0_waitrequest, b_m1_waitrequest;
    logic          a_m0_readdatavalid, a_m1_readdatavalid, b_m0_readdatavalid, b_m1_readdatavalid;
    logic [AW-1:0] a_ram_address, b_ram_address;
    logic [BW-1:0] a_ram_byteenable, b_ram_byteenable;
    logic          a_ram_chipselect, a_ram_write, a_ram_debugaccess, a_ram_clken, a_ram_reset_req;
    logic          b_ram_chipselect, b_ram_write, b_ram_debugaccess, b_ram_clken, b_ram_reset_req;
    logic [DW-1:0] a_ram_writedata, b_ram_writedata;
    logic [DW-1:0] a_ram_q, b_ram_q;
`ifdef ROM_ARB_STATS_EN
    logic          stat_clear;
    logic [15:0]   a_stat_conflicts, a_stat_m1_stalls, b_stat_conflicts, b_stat_m1_stalls;
`endif

    int ntests = 0;
    int nfail  = 0;

    logic [DW-1:0] mem [0:511];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_CONSEC(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(a_m0_readdata),
        .m0_waitrequest(a_m0_waitrequest), .m0_readdatavalid(a_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(a_m1_readdata),
        .m1_waitrequest(a_m1_waitrequest), .m1_readdatavalid(a_m1_readdatavalid),
        .ram_address(a_ram_address), .ram_byteenable(a_ram_byteenable),
        .ram_chipselect(a_ram_chipselect), .ram_write(a_ram_write),
        .ram_writedata(a_ram_writedata), .ram_debugaccess(a_ram_debugaccess),
        .ram_clken(a_ram_clken), .ram_reset_req(a_ram_reset_req), .ram_readdata(a_ram_q)
`ifdef ROM_ARB_STATS_EN
        , .stat_clear(stat_clear), .stat_conflicts(a_stat_conflicts), .stat_m1_stalls(a_stat_m1_stalls)
`endif
    );

    rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_CONSEC(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(b_m0_readdata),
        .m0_waitrequest(b_m0_waitrequest), .m0_readdatavalid(b_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(b_m1_readdata),
        .m1_waitrequest(b_m1_waitrequest), .m1_readdatavalid(b_m1_readdatavalid),
        .ram_address(b_ram_address), .ram_byteenable(b_ram_byteenable),
        .ram_chipselect(b_ram_chipselect), .ram_write(b_ram_write),
        .ram_writedata(b_ram_writedata), .ram_debugaccess(b_ram_debugaccess),
        .ram_clken(b_ram_clken), .ram_reset_req(b_ram_reset_req), .ram_readdata(b_ram_q)
`ifdef ROM_ARB_STATS_EN
        , .stat_clear(stat_clear), .stat_conflicts(b_stat_conflicts), .stat_m1_stalls(b_stat_m1_stalls)
`endif
    );

    // Byte-lane RAM behind instance a; instance b's RAM echoes the read address.
    always @(posedge clk) begin
        if (a_ram_chipselect) begin
            if (a_ram_write && a_ram_debugaccess) begin
                for (int k = 0; k < BW; k++)
                    if (a_ram_byteenable[k])
                        mem[a_ram_address][k*8 +: 8] <= a_ram_writedata[k*8 +: 8];
            end else if (!a_ram_write) begin
                a_ram_q <= mem[a_ram_address];
            end
        end
    end

    always @(posedge clk) begin
        if (b_ram_chipselect && !b_ram_write)
            b_ram_q <= {23'd0, b_ram_address};
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        m0_read = 1'b1; m0_address = 9'h010;
        cyc();
        cyc();
        ntests++;
        if (a_m0_waitrequest !== 1'b1 || a_m1_waitrequest !== 1'b1 || b_m0_waitrequest !== 1'b1) begin
            nfail++;
            $display("FAIL rst_wait: got a0=%b a1=%b b0=%b want 1 1 1", a_m0_waitrequest, a_m1_waitrequest, b_m0_waitrequest);
        end
        ntests++;
        if (a_ram_chipselect !== 1'b0 || b_ram_chipselect !== 1'b0) begin
            nfail++;
            $display("FAIL rst_cs: got a=%b b=%b want 0", a_ram_chipselect, b_ram_chipselect);
        end
        ntests++;
        if (a_ram_clken !== 1'b1 || a_ram_reset_req !== 1'b0 || b_ram_clken !== 1'b1 || b_ram_reset_req !== 1'b0) begin
            nfail++;
            $display("FAIL rst_ties: got clken=%b/%b reset_req=%b/%b want 1/1 0/0", a_ram_clken, b_ram_clken, a_ram_reset_req, b_ram_reset_req);
        end
        ntests++;
        if (a_m0_readdatavalid !== 1'b0 || a_m1_readdatavalid !== 1'b0 || a_m0_readdata !== 32'h0 || a_m1_readdata !== 32'h0) begin
            nfail++;
            $display("FAIL rst_rdata: got v=%b%b d0=%h d1=%h want 00 0 0", a_m0_readdatavalid, a_m1_readdatavalid, a_m0_readdata, a_m1_readdata);
        end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_read();
        cyc();
        m0_read = 1'b1; m0_address = 9'h010;
        #1;
        ntests++;
        if (a_m0_waitrequest !== 1'b0 || a_ram_chipselect !== 1'b1 || a_ram_write !== 1'b0 || a_ram_address !== 9'h010) begin
            nfail++;
            $display("FAIL rd_issue: got wait=%b cs=%b wr=%b addr=%h want 0 1 0 010", a_m0_waitrequest, a_ram_chipselect, a_ram_write, a_ram_address);
        end
        cyc();
        idle();
        #1;
        ntests++;
        if (a_m0_readdatavalid !== 1'b1 || a_m0_readdata !== 32'hDEADBEEF) begin
            nfail++;
            $display("FAIL rd_return: got v=%b d=%h want 1 deadbeef", a_m0_readdatavalid, a_m0_readdata);
        end
        ntests++;
        if (a_m1_readdatavalid !== 1'b0 || a_m1_readdata !== 32'h0) begin
            nfail++;
            $display("FAIL rd_other: got v=%b d=%h want 0 0", a_m1_readdatavalid, a_m1_readdata);
        end
        cyc();
        #1;
        ntests++;
        if (a_m0_readdatavalid !== 1'b0) begin
            nfail++;
            $display("FAIL rd_single: got v=%b want 0", a_m0_readdatavalid);
        end
    endtask

    task automatic test_write_then_read();
        cyc();
        m1_write = 1'b1; m1_address = 9'h1FF; m1_byteenable = 4'h3; m1_writedata = 32'h12345678;
        #1;
        ntests++;
        if (a_m1_waitrequest !== 1'b0 || a_ram_write !== 1'b1 || a_ram_debugaccess !== 1'b1) begin
            nfail++;
            $display("FAIL wr_strobe: got wait=%b wr=%b dbg=%b want 0 1 1", a_m1_waitrequest, a_ram_write, a_ram_debugaccess);
        end
        ntests++;
        if (a_ram_byteenable !== 4'h3 || a_ram_writedata !== 32'h12345678 || a_ram_address !== 9'h1FF) begin
            nfail++;
            $display("FAIL wr_bus: got be=%h wd=%h addr=%h want 3 12345678 1ff", a_ram_byteenable, a_ram_writedata, a_ram_address);
        end
        cyc();
        idle();
        m0_read = 1'b1; m0_address = 9'h1FF;
        #1;
        ntests++;
        if (a_m1_readdatavalid !== 1'b0 || a_m0_waitrequest !== 1'b0 || a_ram_debugaccess !== 1'b0) begin
            nfail++;
            $display("FAIL wr_posted: got v1=%b wait0=%b dbg=%b want 0 0 0", a_m1_readdatavalid, a_m0_waitrequest, a_ram_debugaccess);
        end
        cyc();
        idle();
        #1;
        ntests++;
        if (a_m0_readdatavalid !== 1'b1 || a_m0_readdata !== 32'hAABB5678) begin
            nfail++;
            $display("FAIL wr_readback: got v=%b d=%h want 1 aabb5678", a_m0_readdatavalid, a_m0_readdata);
        end
    endtask

    task automatic test_round_robin();
        logic          exp_a;
        logic          prev_a;
        logic          exp_b;
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        prev_a = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc();
            m0_read = 1'b1; m0_address = 9'h020;
            m1_read = 1'b1; m1_address = 9'h030;
            #1;
            exp_a = ((i / 4) % 2) == 1;
            exp_b = (i % 2) == 1;
            ntests++;
            if (a_m0_waitrequest !== exp_a || a_m1_waitrequest !== ~exp_a) begin
                nfail++;
                $display("FAIL rr4_grant[%0d]: got wait0=%b wait1=%b want %b %b", i, a_m0_waitrequest, a_m1_waitrequest, exp_a, ~exp_a);
            end
            ntests++;
            if (b_m0_waitrequest !== exp_b || b_m1_waitrequest !== ~exp_b) begin
                nfail++;
                $display("FAIL rr1_grant[%0d]: got wait0=%b wait1=%b want %b %b", i, b_m0_waitrequest, b_m1_waitrequest, exp_b, ~exp_b);
            end
            if (i > 0) begin
                ntests++;
                if (a_m0_readdatavalid !== ~prev_a || a_m1_readdatavalid !== prev_a) begin
                    nfail++;
                    $display("FAIL rr4_valid[%0d]: got v0=%b v1=%b want %b %b", i, a_m0_readdatavalid, a_m1_readdatavalid, ~prev_a, prev_a);
                end
                want = prev_a ? 32'h0000B000 : 32'h0000A000;
                got  = prev_a ? a_m1_readdata : a_m0_readdata;
                ntests++;
                if (got !== want) begin
                    nfail++;
                    $display("FAIL rr4_data[%0d]: got %h want %h", i, got, want);
                end
            end
            prev_a = exp_a;
        end
        cyc();
        idle();
        #1;
        ntests++;
        if (a_m0_readdatavalid !== 1'b1 || a_m0_readdata !== 32'h0000A000 || a_m1_readdatavalid !== 1'b0) begin
            nfail++;
            $display("FAIL rr4_tail: got v0=%b d0=%h v1=%b want 1 0000a000 0", a_m0_readdatavalid, a_m0_readdata, a_m1_readdatavalid);
        end
    endtask

    task automatic test_tie_max1();
        do_reset();
        cyc();
        m0_read = 1'b1; m0_address = 9'h005;
        m1_write = 1'b1; m1_address = 9'h006; m1_byteenable = 4'hF; m1_writedata = 32'hCAFE0006;
        #1;
        ntests++;
        if (b_m0_waitrequest !== 1'b0 || b_m1_waitrequest !== 1'b1 || a_m0_waitrequest !== 1'b0) begin
            nfail++;
            $display("FAIL tie_first: got b0=%b b1=%b a0=%b want 0 1 0", b_m0_waitrequest, b_m1_waitrequest, a_m0_waitrequest);
        end
        cyc();
        #1;
        ntests++;
        if (b_m1_waitrequest !== 1'b0 || b_m0_waitrequest !== 1'b1 || a_m1_waitrequest !== 1'b1) begin
            nfail++;
            $display("FAIL tie_second: got b1=%b b0=%b a1=%b want 0 1 1", b_m1_waitrequest, b_m0_waitrequest, a_m1_waitrequest);
        end
        ntests++;
        if (b_ram_write !== 1'b1 || b_ram_debugaccess !== 1'b1 || b_ram_writedata !== 32'hCAFE0006 || b_ram_byteenable !== 4'hF) begin
            nfail++;
            $display("FAIL tie_wbus: got wr=%b dbg=%b wd=%h be=%h want 1 1 cafe0006 f", b_ram_write, b_ram_debugaccess, b_ram_writedata, b_ram_byteenable);
        end
        ntests++;
        if (b_m0_readdatavalid !== 1'b1 || b_m0_readdata !== 32'h00000005) begin
            nfail++;
            $display("FAIL tie_rdata: got v=%b d=%h want 1 00000005", b_m0_readdatavalid, b_m0_readdata);
        end
        cyc();
        m1_write = 1'b0;
        #1;
        ntests++;
        if (b_m0_waitrequest !== 1'b0 || b_m0_readdatavalid !== 1'b0 || b_m1_readdatavalid !== 1'b0 || b_m1_readdata !== 32'h0) begin
            nfail++;
            $display("FAIL tie_after: got w0=%b v0=%b v1=%b d1=%h want 0 0 0 0", b_m0_waitrequest, b_m0_readdatavalid, b_m1_readdatavalid, b_m1_readdata);
        end
        cyc();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc();
        m1_read = 1'b1; m1_address = 9'h030;
        reset = 1'b1;
        #1;
        ntests++;
        if (a_m1_waitrequest !== 1'b1 || a_ram_chipselect !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid_gate: got wait1=%b cs=%b want 1 0", a_m1_waitrequest, a_ram_chipselect);
        end
        cyc();
        reset = 1'b0;
        idle();
        #1;
        ntests++;
        if (a_m1_readdatavalid !== 1'b0 || a_m1_readdata !== 32'h0 || a_m0_readdata !== 32'h0) begin
            nfail++;
            $display("FAIL rstmid_novalid: got v1=%b d1=%h d0=%h want 0 0 0", a_m1_readdatavalid, a_m1_readdata, a_m0_readdata);
        end
        cyc();
        m1_read = 1'b1; m1_address = 9'h030;
        #1;
        ntests++;
        if (a_m1_waitrequest !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid_grant: got wait1=%b want 0", a_m1_waitrequest);
        end
        cyc();
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
        #1;
        ntests++;
        if (a_m1_readdatavalid !== 1'b0 || a_m0_readdatavalid !== 1'b0 || a_m1_readdata !== 32'h0) begin
            nfail++;
            $display("FAIL rstmid_flush: got v1=%b v0=%b d1=%h want 0 0 0", a_m1_readdatavalid, a_m0_readdatavalid, a_m1_readdata);
        end
    endtask

`ifdef ROM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            m0_read = 1'b1; m0_address = 9'h020;
            m1_read = 1'b1; m1_address = 9'h030;
        end
        cyc();
        idle();
        #1;
        ntests++;
        if (b_stat_conflicts !== 16'd10 || b_stat_m1_stalls !== 16'd5) begin
            nfail++;
            $display("FAIL stats_max1: got conf=%0d stall=%0d want 10 5", b_stat_conflicts, b_stat_m1_stalls);
        end
        ntests++;
        if (a_stat_conflicts !== 16'd10 || a_stat_m1_stalls !== 16'd6) begin
            nfail++;
            $display("FAIL stats_max4: got conf=%0d stall=%0d want 10 6", a_stat_conflicts, a_stat_m1_stalls);
        end
        stat_clear = 1'b1;
        m0_read = 1'b1; m1_read = 1'b1;
        cyc();
        stat_clear = 1'b0;
        idle();
        #1;
        ntests++;
        if (b_stat_conflicts !== 16'd0 || b_stat_m1_stalls !== 16'd0) begin
            nfail++;
            $display("FAIL stats_clear: got conf=%0d stall=%0d want 0 0", b_stat_conflicts, b_stat_m1_stalls);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle();
`ifdef ROM_ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        mem[9'h010] = 32'hDEADBEEF;
        mem[9'h1FF] = 32'hAABBCCDD;
        mem[9'h020] = 32'h0000A000;
        mem[9'h030] = 32'h0000B000;
        a_ram_q = '0;
        b_ram_q = '0;
        test_reset();
        test_read();
        test_write_then_read();
        test_round_robin();
        test_tie_max1();
        test_reset_mid();
`ifdef ROM_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
